// File: rtl/mcpu_mem_iface.sv
// mcpu_mem_iface
// Memory/IO access sequencer between the multi-cycle CPU core and the MIO bus.
// Handles byte/halfword/word loads and stores with lane steering, sign or zero
// extension of load data, alignment checking and a wait on MIO_ready.
// One request is in flight at a time and each accepted request gets exactly
// one response.
//
// Optional feature: define MIU_TIMEOUT_EN to enable a bus timeout. When the
// bus has not acknowledged within TIMEOUT_CYC ACCESS cycles the request is
// answered with rsp_code 2'b10. Without the macro, ACCESS waits indefinitely.

module mcpu_mem_iface #(
   parameter int ADDR_W      = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic [1:0]        rsp_code,
   input  logic              MIO_ready,
   input  logic [31:0]       Data_in,
   output logic [ADDR_W-1:0] Addr_out,
   output logic [31:0]       Data_out,
   output logic [3:0]        byte_en,
   output logic              mem_w,
   output logic              CPU_MIO
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCESS = 2'b01,
      RESP   = 2'b10
   } state_t;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   localparam logic [1:0] CODE_OK  = 2'b00;
   localparam logic [1:0] CODE_MIS = 2'b01;
   localparam logic [1:0] CODE_TO  = 2'b10;

   state_t state_q, state_d;

   logic              we_q, we_d;
   logic [1:0]        size_q, size_d;
   logic              signed_q, signed_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       busData_q, busData_d;
   logic [1:0]        code_q, code_d;

   logic        misalignReq;
   logic        timeoutHit;
   logic [3:0]  laneEn;
   logic [31:0] laneData;
   logic [7:0]  byteSel;
   logic [15:0] halfSel;
   logic [31:0] loadData;

   // Alignment of the incoming request; reserved size 11 never aligns
   always_comb begin
      misalignReq = 1'b0;
      case (req_size)
         SIZE_BYTE: misalignReq = 1'b0;
         SIZE_HALF: misalignReq = req_addr[0];
         SIZE_WORD: misalignReq = (req_addr[1:0] != 2'b00);
         default:   misalignReq = 1'b1;
      endcase
   end

`ifdef MIU_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYC > 255) ? 16 : 8;

   logic [CNT_W-1:0] waitCnt_q, waitCnt_d;

   // Wait counter: held at zero outside ACCESS so it starts fresh on entry
   always_comb begin
      waitCnt_d = waitCnt_q;
      if (state_q != ACCESS) begin
         waitCnt_d = '0;
      end else if (!MIO_ready) begin
         waitCnt_d = waitCnt_q + CNT_W'(1);
      end
   end

   // Wait counter register
   always_ff @(posedge clk) begin
      if (reset) begin
         waitCnt_q <= '0;
      end else begin
         waitCnt_q <= waitCnt_d;
      end
   end

   // The limit is hit on the last permitted unacknowledged cycle; a ready in
   // that same cycle takes precedence and completes normally
   assign timeoutHit = (state_q == ACCESS) && !MIO_ready &&
                       (waitCnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
   assign timeoutHit = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: misaligned requests skip the bus entirely
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               state_d = misalignReq ? RESP : ACCESS;
            end
         end
         ACCESS: begin
            if (MIO_ready || timeoutHit) begin
               state_d = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Request latch and bus capture: fields are taken on acceptance, read data
   // is taken only on the acknowledged ACCESS cycle
   always_comb begin
      we_d      = we_q;
      size_d    = size_q;
      signed_d  = signed_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      busData_d = busData_q;
      code_d    = code_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d      = req_we;
               size_d    = req_size;
               signed_d  = req_signed;
               addr_d    = req_addr;
               wdata_d   = req_wdata;
               busData_d = '0;
               code_d    = misalignReq ? CODE_MIS : CODE_OK;
            end
         end
         ACCESS: begin
            if (MIO_ready) begin
               busData_d = Data_in;
            end else if (timeoutHit) begin
               code_d = CODE_TO;
            end
         end
         default: ;
      endcase
   end

   // Request latch register
   always_ff @(posedge clk) begin
      if (reset) begin
         we_q      <= 1'b0;
         size_q    <= 2'b00;
         signed_q  <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         busData_q <= '0;
         code_q    <= CODE_OK;
      end else begin
         we_q      <= we_d;
         size_q    <= size_d;
         signed_q  <= signed_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         busData_q <= busData_d;
         code_q    <= code_d;
      end
   end

   // Store lane steering: enables by size/offset, data replicated across lanes
   always_comb begin
      laneEn   = 4'b1111;
      laneData = wdata_q;
      case (size_q)
         SIZE_BYTE: begin
            laneEn   = 4'b0001 << addr_q[1:0];
            laneData = {4{wdata_q[7:0]}};
         end
         SIZE_HALF: begin
            laneEn   = addr_q[1] ? 4'b1100 : 4'b0011;
            laneData = {2{wdata_q[15:0]}};
         end
         default: begin
            laneEn   = 4'b1111;
            laneData = wdata_q;
         end
      endcase
   end

   // Load lane selection and extension; stores and errors return zero
   always_comb begin
      byteSel = busData_q[7:0];
      case (addr_q[1:0])
         2'b00: byteSel = busData_q[7:0];
         2'b01: byteSel = busData_q[15:8];
         2'b10: byteSel = busData_q[23:16];
         2'b11: byteSel = busData_q[31:24];
         default: byteSel = busData_q[7:0];
      endcase
      halfSel = addr_q[1] ? busData_q[31:16] : busData_q[15:0];
      case (size_q)
         SIZE_BYTE: loadData = signed_q ? {{24{byteSel[7]}}, byteSel} : {24'h000000, byteSel};
         SIZE_HALF: loadData = signed_q ? {{16{halfSel[15]}}, halfSel} : {16'h0000, halfSel};
         default:   loadData = busData_q;
      endcase
      if (we_q || (code_q != CODE_OK)) begin
         loadData = '0;
      end
   end

   // Outputs decoded from state; bus is driven only in ACCESS, response only in RESP
   always_comb begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_rdata = '0;
      rsp_err   = 1'b0;
      rsp_code  = CODE_OK;
      CPU_MIO   = 1'b0;
      mem_w     = 1'b0;
      Addr_out  = '0;
      byte_en   = 4'b0000;
      Data_out  = '0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
         end
         ACCESS: begin
            CPU_MIO  = 1'b1;
            mem_w    = we_q;
            Addr_out = {addr_q[ADDR_W-1:2], 2'b00};
            byte_en  = laneEn;
            Data_out = laneData;
         end
         RESP: begin
            rsp_valid = 1'b1;
            rsp_rdata = loadData;
            rsp_err   = (code_q != CODE_OK);
            rsp_code  = code_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mcpu_mem_iface.sv
// tb_mcpu_mem_iface
// Table-driven bench for mcpu_mem_iface plus hand-written sequences for reset
// during a bus cycle, back-to-back requests and the bus timeout (MIU_TIMEOUT_EN).
// Expected responses go into a queue when a request is driven and are popped
// by a monitor whenever rsp_valid is seen.

module tb_mcpu_mem_iface;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [1:0]  rsp_code;
   logic        MIO_ready;
   logic [31:0] Data_in;
   logic [31:0] Addr_out;
   logic [31:0] Data_out;
   logic [3:0]  byte_en;
   logic        mem_w;
   logic        CPU_MIO;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] dataIn;
      int          waitCyc;
      logic [31:0] expAddr;
      logic [3:0]  expBe;
      logic [31:0] expData;
      logic [31:0] expRdata;
      logic        expErr;
      logic [1:0]  expCode;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic [1:0]  code;
   } resp_t;

   resp_t expQ[$];
   vec_t  vecs[16];

   mcpu_mem_iface #(
      .ADDR_W(32),
      .TIMEOUT_CYC(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_we(req_we),
      .req_size(req_size),
      .req_signed(req_signed),
      .req_addr(req_addr),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err),
      .rsp_code(rsp_code),
      .MIO_ready(MIO_ready),
      .Data_in(Data_in),
      .Addr_out(Addr_out),
      .Data_out(Data_out),
      .byte_en(byte_en),
      .mem_w(mem_w),
      .CPU_MIO(CPU_MIO)
   );

   // 10-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case a sequence runs away
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Response scoreboard: every rsp_valid must match the oldest expectation
   always @(negedge clk) begin
      if (rsp_valid === 1'b1) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected rsp_valid", {31'b0, rsp_valid}, 32'h0);
         end else begin
            resp_t r;
            r = expQ.pop_front();
            checkOutput("rsp_rdata", rsp_rdata, r.rdata);
            checkOutput("rsp_err", {31'b0, rsp_err}, {31'b0, r.err});
            checkOutput("rsp_code", {30'b0, rsp_code}, {30'b0, r.code});
         end
      end
   end

   // Present a request for one accepting edge; ends at the following negedge
   task automatic applyStimulus(input vec_t v);
      resp_t r;
      req_valid  = 1'b1;
      req_we     = v.we;
      req_size   = v.size;
      req_signed = v.sgn;
      req_addr   = v.addr;
      req_wdata  = v.wdata;
      MIO_ready  = 1'b0;
      r.rdata = v.expRdata;
      r.err   = v.expErr;
      r.code  = v.expCode;
      expQ.push_back(r);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Full transaction with bus checks on every ACCESS cycle and latency checks
   task automatic runVector(input string tag, input vec_t v);
      applyStimulus(v);
      if (v.expCode == 2'b01) begin
         checkOutput({tag, " misaligned rsp_valid at accept+1"}, {31'b0, rsp_valid}, 32'h1);
         checkOutput({tag, " misaligned CPU_MIO"}, {31'b0, CPU_MIO}, 32'h0);
         checkOutput({tag, " misaligned mem_w"}, {31'b0, mem_w}, 32'h0);
      end else begin
         for (int w = 0; w <= v.waitCyc; w++) begin
            checkOutput({tag, " CPU_MIO"}, {31'b0, CPU_MIO}, 32'h1);
            checkOutput({tag, " mem_w"}, {31'b0, mem_w}, {31'b0, v.we});
            checkOutput({tag, " Addr_out"}, Addr_out, v.expAddr);
            checkOutput({tag, " byte_en"}, {28'b0, byte_en}, {28'b0, v.expBe});
            checkOutput({tag, " Data_out"}, Data_out, v.expData);
            checkOutput({tag, " rsp_valid early"}, {31'b0, rsp_valid}, 32'h0);
            checkOutput({tag, " req_ready busy"}, {31'b0, req_ready}, 32'h0);
            MIO_ready = (w == v.waitCyc);
            Data_in   = (w == v.waitCyc) ? v.dataIn : 32'h5A5A5A5A;
            @(negedge clk);
         end
         MIO_ready = 1'b0;
         Data_in   = 32'hA5A5A5A5;
         checkOutput({tag, " rsp_valid latency"}, {31'b0, rsp_valid}, 32'h1);
         checkOutput({tag, " CPU_MIO in RESP"}, {31'b0, CPU_MIO}, 32'h0);
      end
      @(negedge clk);
      checkOutput({tag, " rsp_valid single cycle"}, {31'b0, rsp_valid}, 32'h0);
      checkOutput({tag, " req_ready after RESP"}, {31'b0, req_ready}, 32'h1);
   endtask

   initial begin
      vec_t v;

      //          we    size   sgn   addr          wdata         dataIn        wt  expAddr       be       expData       expRdata      err   code
      vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h00000010, 32'hDEADBEEF, 32'h00000000, 3, 32'h00000010, 4'b1111, 32'hDEADBEEF, 32'h00000000, 1'b0, 2'b00};
      vecs[1]  = '{1'b0, 2'b00, 1'b1, 32'h00000013, 32'h00000000, 32'h80123456, 0, 32'h00000010, 4'b1000, 32'h00000000, 32'hFFFFFF80, 1'b0, 2'b00};
      vecs[2]  = '{1'b0, 2'b00, 1'b0, 32'h00000013, 32'h00000000, 32'h80123456, 0, 32'h00000010, 4'b1000, 32'h00000000, 32'h00000080, 1'b0, 2'b00};
      vecs[3]  = '{1'b1, 2'b01, 1'b0, 32'h00000022, 32'h0000ABCD, 32'h00000000, 1, 32'h00000020, 4'b1100, 32'hABCDABCD, 32'h00000000, 1'b0, 2'b00};
      vecs[4]  = '{1'b0, 2'b01, 1'b0, 32'h00000021, 32'h00000000, 32'h00000000, 0, 32'h00000000, 4'b0000, 32'h00000000, 32'h00000000, 1'b1, 2'b01};
      vecs[5]  = '{1'b0, 2'b01, 1'b1, 32'h00000012, 32'h00000000, 32'h80017FFF, 2, 32'h00000010, 4'b1100, 32'h00000000, 32'hFFFF8001, 1'b0, 2'b00};
      vecs[6]  = '{1'b0, 2'b01, 1'b1, 32'h00000010, 32'h00000000, 32'h80017FFF, 0, 32'h00000010, 4'b0011, 32'h00000000, 32'h00007FFF, 1'b0, 2'b00};
      vecs[7]  = '{1'b1, 2'b00, 1'b0, 32'h00000001, 32'h123456A5, 32'h00000000, 0, 32'h00000000, 4'b0010, 32'hA5A5A5A5, 32'h00000000, 1'b0, 2'b00};
      vecs[8]  = '{1'b0, 2'b10, 1'b1, 32'h00000004, 32'h00000000, 32'hCAFEF00D, 1, 32'h00000004, 4'b1111, 32'h00000000, 32'hCAFEF00D, 1'b0, 2'b00};
      vecs[9]  = '{1'b0, 2'b10, 1'b0, 32'h00000006, 32'h00000000, 32'h00000000, 0, 32'h00000000, 4'b0000, 32'h00000000, 32'h00000000, 1'b1, 2'b01};
      vecs[10] = '{1'b1, 2'b11, 1'b0, 32'h00000000, 32'h11111111, 32'h00000000, 0, 32'h00000000, 4'b0000, 32'h00000000, 32'h00000000, 1'b1, 2'b01};
      vecs[11] = '{1'b0, 2'b00, 1'b0, 32'h00000000, 32'h00000000, 32'h000000FF, 0, 32'h00000000, 4'b0001, 32'h00000000, 32'h000000FF, 1'b0, 2'b00};
      vecs[12] = '{1'b0, 2'b00, 1'b1, 32'h00000001, 32'h00000000, 32'h00007F00, 0, 32'h00000000, 4'b0010, 32'h00000000, 32'h0000007F, 1'b0, 2'b00};
      vecs[13] = '{1'b1, 2'b01, 1'b0, 32'hFFFFFFFE, 32'h00001234, 32'h00000000, 0, 32'hFFFFFFFC, 4'b1100, 32'h12341234, 32'h00000000, 1'b0, 2'b00};
      vecs[14] = '{1'b0, 2'b00, 1'b1, 32'h00000012, 32'h00000000, 32'h00C30000, 0, 32'h00000010, 4'b0100, 32'h00000000, 32'hFFFFFFC3, 1'b0, 2'b00};
      vecs[15] = '{1'b0, 2'b01, 1'b0, 32'h00000012, 32'h00000000, 32'h80010000, 0, 32'h00000010, 4'b1100, 32'h00000000, 32'h00008001, 1'b0, 2'b00};

      reset      = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_size   = 2'b00;
      req_signed = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      MIO_ready  = 1'b1;
      Data_in    = '0;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      checkOutput("reset req_ready", {31'b0, req_ready}, 32'h1);
      checkOutput("reset CPU_MIO", {31'b0, CPU_MIO}, 32'h0);
      checkOutput("reset mem_w", {31'b0, mem_w}, 32'h0);
      checkOutput("reset rsp_valid", {31'b0, rsp_valid}, 32'h0);
      checkOutput("reset Addr_out", Addr_out, 32'h0);
      checkOutput("reset byte_en", {28'b0, byte_en}, 32'h0);
      reset     = 1'b0;
      MIO_ready = 1'b0;
      @(negedge clk);

      // Table of single transactions
      for (int i = 0; i < 16; i++) begin
         runVector($sformatf("v%0d", i), vecs[i]);
      end

      // Reset on the 2nd ACCESS cycle of a store abandons it
      v = '{1'b1, 2'b10, 1'b0, 32'h00000040, 32'h11112222, 32'h0, 0, 32'h40, 4'b1111, 32'h11112222, 32'h0, 1'b0, 2'b00};
      applyStimulus(v);
      checkOutput("rst-seq CPU_MIO cycle1", {31'b0, CPU_MIO}, 32'h1);
      @(negedge clk);
      checkOutput("rst-seq mem_w cycle2", {31'b0, mem_w}, 32'h1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      expQ.delete();
      checkOutput("rst-seq mem_w after reset", {31'b0, mem_w}, 32'h0);
      checkOutput("rst-seq CPU_MIO after reset", {31'b0, CPU_MIO}, 32'h0);
      checkOutput("rst-seq req_ready after reset", {31'b0, req_ready}, 32'h1);
      checkOutput("rst-seq rsp_valid after reset", {31'b0, rsp_valid}, 32'h0);
      MIO_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkOutput("rst-seq no response", {31'b0, rsp_valid}, 32'h0);
      end
      MIO_ready = 1'b0;

      // Back-to-back requests with req_valid held and MIO_ready always high
      v = '{1'b0, 2'b10, 1'b0, 32'h00000050, 32'h0, 32'h0, 0, 32'h50, 4'b1111, 32'h0, 32'h01020304, 1'b0, 2'b00};
      expQ.push_back('{v.expRdata, v.expErr, v.expCode});
      req_valid  = 1'b1;
      req_we     = v.we;
      req_size   = v.size;
      req_signed = v.sgn;
      req_addr   = v.addr;
      req_wdata  = v.wdata;
      MIO_ready  = 1'b1;
      Data_in    = 32'h01020304;
      @(negedge clk);
      checkOutput("b2b first ACCESS", {31'b0, CPU_MIO}, 32'h1);
      @(negedge clk);
      checkOutput("b2b first rsp_valid", {31'b0, rsp_valid}, 32'h1);
      req_size   = 2'b00;
      req_signed = 1'b1;
      req_addr   = 32'h00000052;
      Data_in    = 32'h00F00000;
      expQ.push_back('{32'hFFFFFFF0, 1'b0, 2'b00});
      @(negedge clk);
      checkOutput("b2b IDLE req_ready", {31'b0, req_ready}, 32'h1);
      checkOutput("b2b IDLE rsp_valid", {31'b0, rsp_valid}, 32'h0);
      @(negedge clk);
      req_valid = 1'b0;
      checkOutput("b2b second ACCESS", {31'b0, CPU_MIO}, 32'h1);
      checkOutput("b2b second byte_en", {28'b0, byte_en}, 32'h4);
      @(negedge clk);
      checkOutput("b2b second rsp_valid", {31'b0, rsp_valid}, 32'h1);
      MIO_ready = 1'b0;
      @(negedge clk);
      checkOutput("b2b back to IDLE", {31'b0, req_ready}, 32'h1);

`ifdef MIU_TIMEOUT_EN
      // Bus never acknowledges: timeout after 4 ACCESS cycles
      v = '{1'b0, 2'b10, 1'b0, 32'h00000030, 32'h0, 32'h0, 0, 32'h30, 4'b1111, 32'h0, 32'h00000000, 1'b1, 2'b10};
      applyStimulus(v);
      Data_in = 32'h77777777;
      for (int k = 0; k < 4; k++) begin
         checkOutput("timeout CPU_MIO while waiting", {31'b0, CPU_MIO}, 32'h1);
         @(negedge clk);
      end
      checkOutput("timeout rsp_valid", {31'b0, rsp_valid}, 32'h1);
      checkOutput("timeout CPU_MIO dropped", {31'b0, CPU_MIO}, 32'h0);
      @(negedge clk);
      checkOutput("timeout back to IDLE", {31'b0, req_ready}, 32'h1);
`else
      // Without the timeout the bus cycle waits for as long as it takes
      v = '{1'b0, 2'b10, 1'b0, 32'h00000030, 32'h0, 32'h600DF00D, 20, 32'h30, 4'b1111, 32'h0, 32'h600DF00D, 1'b0, 2'b00};
      runVector("long-wait", v);
`endif

      @(negedge clk);
      checkOutput("scoreboard drained", expQ.size(), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
